seq_multiplier_param: RTL and testbench

//  Parametrised sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH.
//  - Runtime signed/unsigned mode; radix selectable via BITS_PER_CYCLE.
//  - Operands latched at start; start/busy/done handshake.
//  - Used by the QOA decoder datapath (LMS prediction, dequant scaling) wherever area beats latency.
//

---
 rtl/seq_multiplier_param_if.sv | 32 +++
 rtl/seq_multiplier_param.sv | 110 +++++++++++
 tb/tb_seq_multiplier_param.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_param_if.sv
// Handshake bundle for seq_multiplier_param: request/operands in, busy/done/result out.
// With MULT_ACC_EN defined the bundle also carries the acc_en request bit.
interface seq_multiplier_param_if #(
  parameter int WIDTH = 16
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     operand_a;
  logic [WIDTH-1:0]     operand_b;
`ifdef MULT_ACC_EN
  logic                 acc_en;
`endif
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output start, signed_mode, operand_a, operand_b,
`ifdef MULT_ACC_EN
    output acc_en,
`endif
    input  busy, done, result
  );

  modport slave (
    input  start, signed_mode, operand_a, operand_b,
`ifdef MULT_ACC_EN
    input  acc_en,
`endif
    output busy, done, result
  );
endinterface

// File: rtl/seq_multiplier_param.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, BITS_PER_CYCLE multiplier bits per step.
// Optional MULT_ACC_EN macro adds acc_en: result accumulates the signed product instead of replacing it.
module seq_multiplier_param #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  seq_multiplier_param_if.slave bus
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, MUL, FIX} state_t;

  state_t                state_q, state_d;
  logic                  load_en, step_en, fix_en;
  logic [WIDTH-1:0]      a_mag_q;
  logic [PW-1:0]         b_sh_q;
  logic [PW-1:0]         partial_q;
  logic [CNT_W-1:0]      count_q;
  logic                  sign_q;
  logic                  done_q;
  logic [PW-1:0]         result_q;
  logic signed [PW-1:0]  product_s;
`ifdef MULT_ACC_EN
  logic                  acc_q;
`endif

  // Two's-complement magnitude; the most-negative value maps to 2^(WIDTH-1), still exact in WIDTH bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sm);
    return (sm && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic signed [PW-1:0] apply_sign(input logic [PW-1:0] p, input logic neg);
    return neg ? $signed(-p) : $signed(p);
  endfunction

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = MUL;
      MUL:     if (count_q == LAST_STEP) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_en  = (state_q == IDLE) && bus.start;
    step_en  = (state_q == MUL);
    fix_en   = (state_q == FIX);
    bus.busy = (state_q == MUL) || (state_q == FIX);
  end

  assign product_s  = apply_sign(partial_q, sign_q);
  assign bus.done   = done_q;
  assign bus.result = result_q;

  // Operand capture and one multiplier digit per MUL cycle; b is pre-shifted so no count*BPC shifter is needed.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      a_mag_q   <= '0;
      b_sh_q    <= '0;
      partial_q <= '0;
      count_q   <= '0;
      sign_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
`ifdef MULT_ACC_EN
      acc_q     <= 1'b0;
`endif
    end else begin
      done_q <= fix_en;
      if (load_en) begin
        a_mag_q   <= magnitude(bus.operand_a, bus.signed_mode);
        b_sh_q    <= PW'(magnitude(bus.operand_b, bus.signed_mode));
        sign_q    <= bus.signed_mode & (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
        partial_q <= '0;
        count_q   <= '0;
`ifdef MULT_ACC_EN
        acc_q     <= bus.acc_en;
`endif
      end
      if (step_en) begin
        partial_q <= partial_q + b_sh_q * PW'(a_mag_q[BITS_PER_CYCLE-1:0]);
        b_sh_q    <= b_sh_q << BITS_PER_CYCLE;
        a_mag_q   <= a_mag_q >> BITS_PER_CYCLE;
        count_q   <= count_q + 1'b1;
      end
      // FIX -> IDLE: the only point where result moves.
      if (fix_en) begin
`ifdef MULT_ACC_EN
        result_q <= acc_q ? result_q + product_s : product_s;
`else
        result_q <= product_s;
`endif
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Bench for seq_multiplier_param: radix-2 directed/random checks, handshake and reset behaviour,
// plus a radix-16 / radix-65536 random sweep against a plain-arithmetic product model.
module tb_seq_multiplier_param;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  int vec = 0;
  int mis = 0;

  seq_multiplier_param_if #(.WIDTH(16)) m1 ();
  seq_multiplier_param_if #(.WIDTH(16)) m4 ();
  seq_multiplier_param_if #(.WIDTH(16)) m16 ();

  seq_multiplier_param #(.WIDTH(16), .BITS_PER_CYCLE(1))  dut1  (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(m1));
  seq_multiplier_param #(.WIDTH(16), .BITS_PER_CYCLE(4))  dut4  (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(m4));
  seq_multiplier_param #(.WIDTH(16), .BITS_PER_CYCLE(16)) dut16 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(m16));

  function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b, input logic sm);
    longint p;
    if (sm) p = longint'($signed(a)) * longint'($signed(b));
    else    p = longint'(a) * longint'(b);
    return p[31:0];
  endfunction

  // Runs one op on the radix-2 unit, scrambling inputs after the start cycle; reports what was seen.
  task automatic do_op1(input logic [15:0] a, input logic [15:0] b, input logic sm, input logic acc,
                        output int done_cyc, output int done_cnt, output int busy_first,
                        output int busy_last, output logic [31:0] res);
    @(posedge sys_clk); #1;
    m1.start = 1'b1; m1.signed_mode = sm; m1.operand_a = a; m1.operand_b = b;
`ifdef MULT_ACC_EN
    m1.acc_en = acc;
`else
    if (acc) $display("note: accumulate requested without accumulator build");
`endif
    @(posedge sys_clk); #1;
    m1.start = 1'b0; m1.signed_mode = ~sm;
    m1.operand_a = 16'($urandom); m1.operand_b = 16'($urandom);
`ifdef MULT_ACC_EN
    m1.acc_en = ~acc;
`endif
    done_cyc = -1; done_cnt = 0; busy_first = -1; busy_last = -1; res = '0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge sys_clk);
      if (m1.busy) begin
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (m1.done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = c; res = m1.result; end
      end
      if (c < 24) @(posedge sys_clk);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    vec++; if (m1.busy !== 1'b0) begin mis++; $display("FAIL reset_busy: got %b want 0", m1.busy); end
    vec++; if (m1.done !== 1'b0) begin mis++; $display("FAIL reset_done: got %b want 0", m1.done); end
    vec++; if (m1.result !== 32'h0) begin mis++; $display("FAIL reset_result: got %h want 0", m1.result); end
    vec++; if (m4.result !== 32'h0) begin mis++; $display("FAIL reset_result4: got %h want 0", m4.result); end
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
  endtask

  task automatic test_directed();
    int dc, dn, bf, bl;
    logic [31:0] r;
    do_op1(16'd3, 16'hFFFB, 1'b1, 1'b0, dc, dn, bf, bl, r);
    vec++; if (r !== 32'hFFFFFFF1) begin mis++; $display("FAIL 3x-5_result: got %h want FFFFFFF1", r); end
    vec++; if (dc !== 18) begin mis++; $display("FAIL 3x-5_done_cycle: got %0d want 18", dc); end
    vec++; if (dn !== 1) begin mis++; $display("FAIL 3x-5_done_pulses: got %0d want 1", dn); end
    vec++; if (bf !== 1) begin mis++; $display("FAIL 3x-5_busy_first: got %0d want 1", bf); end
    vec++; if (bl !== 17) begin mis++; $display("FAIL 3x-5_busy_last: got %0d want 17", bl); end
    do_op1(16'h8000, 16'h8000, 1'b1, 1'b0, dc, dn, bf, bl, r);
    vec++; if (r !== 32'h40000000) begin mis++; $display("FAIL minneg_sq: got %h want 40000000", r); end
    do_op1(16'h7FFF, 16'h8000, 1'b1, 1'b0, dc, dn, bf, bl, r);
    vec++; if (r !== 32'hC0008000) begin mis++; $display("FAIL maxpos_x_minneg: got %h want C0008000", r); end
    do_op1(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, dc, dn, bf, bl, r);
    vec++; if (r !== 32'hFFFE0001) begin mis++; $display("FAIL ffff_sq_unsigned: got %h want FFFE0001", r); end
    do_op1(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, dc, dn, bf, bl, r);
    vec++; if (r !== 32'h00000001) begin mis++; $display("FAIL ffff_sq_signed: got %h want 00000001", r); end
  endtask

  task automatic test_random_bpc1();
    int dc, dn, bf, bl;
    logic [31:0] r, exp_r;
    logic [15:0] a, b;
    logic sm;
    for (int i = 0; i < 20; i++) begin
      a = 16'($urandom); b = 16'($urandom); sm = 1'($urandom);
      exp_r = ref_prod(a, b, sm);
      do_op1(a, b, sm, 1'b0, dc, dn, bf, bl, r);
      vec++; if (r !== exp_r) begin mis++; $display("FAIL rand1_result a=%h b=%h s=%b: got %h want %h", a, b, sm, r, exp_r); end
      vec++; if (dc !== 18) begin mis++; $display("FAIL rand1_latency: got %0d want 18", dc); end
    end
  endtask

  task automatic test_back_to_back();
    int d_first, d_second, d_cnt;
    logic [31:0] r_first, r_second;
    logic [31:0] exp1, exp2;
    exp1 = ref_prod(16'h0123, 16'hFF00, 1'b1);
    exp2 = ref_prod(16'h1234, 16'h0011, 1'b0);
    d_first = -1; d_second = -1; d_cnt = 0; r_first = '0; r_second = '0;
    @(posedge sys_clk); #1;
    m1.start = 1'b1; m1.signed_mode = 1'b1; m1.operand_a = 16'h0123; m1.operand_b = 16'hFF00;
    for (int c = 1; c <= 40; c++) begin
      @(posedge sys_clk); #1;
      if (c < 18) begin
        m1.start = 1'b1; m1.signed_mode = 1'($urandom);
        m1.operand_a = 16'($urandom); m1.operand_b = 16'($urandom);
      end else if (c == 18) begin
        m1.start = 1'b1; m1.signed_mode = 1'b0; m1.operand_a = 16'h1234; m1.operand_b = 16'h0011;
      end else begin
        m1.start = 1'b0; m1.operand_a = 16'($urandom); m1.operand_b = 16'($urandom);
      end
      @(negedge sys_clk);
      if (m1.done) begin
        d_cnt++;
        if (d_first < 0) begin d_first = c; r_first = m1.result; end
        else if (d_second < 0) begin d_second = c; r_second = m1.result; end
      end
    end
    vec++; if (d_first !== 18) begin mis++; $display("FAIL b2b_first_done: got %0d want 18", d_first); end
    vec++; if (r_first !== exp1) begin mis++; $display("FAIL b2b_first_result: got %h want %h", r_first, exp1); end
    vec++; if (d_second !== 36) begin mis++; $display("FAIL b2b_second_done: got %0d want 36", d_second); end
    vec++; if (r_second !== exp2) begin mis++; $display("FAIL b2b_second_result: got %h want %h", r_second, exp2); end
    vec++; if (d_cnt !== 2) begin mis++; $display("FAIL b2b_done_count: got %0d want 2", d_cnt); end
  endtask

  task automatic test_reset_mid();
    int d_cnt;
    @(posedge sys_clk); #1;
    m1.start = 1'b1; m1.signed_mode = 1'b0; m1.operand_a = 16'h1234; m1.operand_b = 16'h0567;
    @(posedge sys_clk); #1;
    m1.start = 1'b0;
    for (int c = 1; c < 7; c++) @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    vec++; if (m1.busy !== 1'b0) begin mis++; $display("FAIL midrst_busy: got %b want 0", m1.busy); end
    vec++; if (m1.done !== 1'b0) begin mis++; $display("FAIL midrst_done: got %b want 0", m1.done); end
    vec++; if (m1.result !== 32'h0) begin mis++; $display("FAIL midrst_result: got %h want 0", m1.result); end
    d_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge sys_clk);
      if (m1.done) d_cnt++;
    end
    vec++; if (d_cnt !== 0) begin mis++; $display("FAIL midrst_stray_done: got %0d want 0", d_cnt); end
  endtask

  task automatic test_sweep();
    logic [15:0] corner [4];
    logic [15:0] a, b;
    logic sm;
    logic [31:0] exp_r, r4, r16;
    int l4, l16;
    corner[0] = 16'h8000; corner[1] = 16'hFFFF; corner[2] = 16'h0000; corner[3] = 16'h7FFF;
    for (int i = 0; i < 1000; i++) begin
      a  = (i < 16) ? corner[i % 4] : 16'($urandom);
      b  = (i < 16) ? corner[(i / 4) % 4] : 16'($urandom);
      sm = (i < 16) ? 1'(i / 8) : 1'($urandom);
      exp_r = ref_prod(a, b, sm);
      @(posedge sys_clk); #1;
      m4.start = 1'b1;  m4.signed_mode = sm;  m4.operand_a = a;  m4.operand_b = b;
      m16.start = 1'b1; m16.signed_mode = sm; m16.operand_a = a; m16.operand_b = b;
      @(posedge sys_clk); #1;
      m4.start = 1'b0;  m4.operand_a = 16'($urandom);  m4.signed_mode = ~sm;
      m16.start = 1'b0; m16.operand_b = 16'($urandom); m16.signed_mode = ~sm;
      l4 = -1; l16 = -1; r4 = '0; r16 = '0;
      for (int c = 1; c <= 8; c++) begin
        @(negedge sys_clk);
        if (m4.done && l4 < 0) begin l4 = c; r4 = m4.result; end
        if (m16.done && l16 < 0) begin l16 = c; r16 = m16.result; end
        if (c < 8) @(posedge sys_clk);
      end
      vec++; if (r4 !== exp_r) begin mis++; $display("FAIL bpc4_result a=%h b=%h s=%b: got %h want %h", a, b, sm, r4, exp_r); end
      vec++; if (l4 !== 6) begin mis++; $display("FAIL bpc4_latency: got %0d want 6", l4); end
      vec++; if (r16 !== exp_r) begin mis++; $display("FAIL bpc16_result a=%h b=%h s=%b: got %h want %h", a, b, sm, r16, exp_r); end
      vec++; if (l16 !== 3) begin mis++; $display("FAIL bpc16_latency: got %0d want 3", l16); end
    end
  endtask

`ifdef MULT_ACC_EN
  task automatic test_accumulate();
    int dc, dn, bf, bl;
    logic [31:0] r, model;
    do_op1(16'd2, 16'd3, 1'b1, 1'b0, dc, dn, bf, bl, r);
    vec++; if (r !== 32'd6) begin mis++; $display("FAIL acc_load: got %h want 6", r); end
    do_op1(16'd4, 16'hFFFB, 1'b1, 1'b1, dc, dn, bf, bl, r);
    vec++; if (r !== 32'hFFFFFFF2) begin mis++; $display("FAIL acc_add_neg: got %h want FFFFFFF2", r); end
    vec++; if (dc !== 18) begin mis++; $display("FAIL acc_latency: got %0d want 18", dc); end
    do_op1(16'h7FFF, 16'h8000, 1'b0, 1'b0, dc, dn, bf, bl, r);
    do_op1(16'h7FFF, 16'h8000, 1'b0, 1'b1, dc, dn, bf, bl, r);
    do_op1(16'hFFFF, 16'h0001, 1'b0, 1'b1, dc, dn, bf, bl, r);
    vec++; if (r !== 32'h7FFFFFFF) begin mis++; $display("FAIL acc_build_max: got %h want 7FFFFFFF", r); end
    do_op1(16'h0001, 16'h0001, 1'b0, 1'b1, dc, dn, bf, bl, r);
    vec++; if (r !== 32'h80000000) begin mis++; $display("FAIL acc_wrap: got %h want 80000000", r); end
    model = 32'h80000000;
    for (int i = 0; i < 10; i++) begin
      logic [15:0] a, b;
      logic sm, ac;
      a = 16'($urandom); b = 16'($urandom); sm = 1'($urandom); ac = 1'($urandom);
      model = ac ? model + ref_prod(a, b, sm) : ref_prod(a, b, sm);
      do_op1(a, b, sm, ac, dc, dn, bf, bl, r);
      vec++; if (r !== model) begin mis++; $display("FAIL acc_rand: got %h want %h", r, model); end
    end
  endtask
`endif

  initial begin
    m1.start = 1'b0;  m1.signed_mode = 1'b0;  m1.operand_a = '0;  m1.operand_b = '0;
    m4.start = 1'b0;  m4.signed_mode = 1'b0;  m4.operand_a = '0;  m4.operand_b = '0;
    m16.start = 1'b0; m16.signed_mode = 1'b0; m16.operand_a = '0; m16.operand_b = '0;
`ifdef MULT_ACC_EN
    m1.acc_en = 1'b0; m4.acc_en = 1'b0; m16.acc_en = 1'b0;
`endif
    test_reset();
    test_directed();
    test_random_bpc1();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
`ifdef MULT_ACC_EN
    test_accumulate();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", vec, mis);
    $fatal(1, "watchdog");
  end

endmodule
